// File: rtl/cmd_sequencer_pkg.sv
// Shared types and opcode constants for the command sequencer and its decoder.
package cmd_sequencer_pkg;

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_BURST  = 3'd2;
    localparam logic [2:0] OP_CLR_LO = 3'd3;
    localparam logic [2:0] OP_CLR_HI = 3'd4;
    localparam logic [2:0] OP_XOR_LO = 3'd5;
    localparam logic [2:0] OP_XOR_HI = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        EXEC = S_EXEC,
        RESP = S_RESP
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD  = 3'd0,
        CLS_ADD   = 3'd1,
        CLS_BURST = 3'd2,
        CLS_CLEAR = 3'd3,
        CLS_XOR   = 3'd4
    } op_class_t;

endpackage

// File: rtl/cmd_decoder.sv
// Combinational opcode-to-operation-class decode; every 3-bit opcode maps to a class.
module cmd_decoder
    import cmd_sequencer_pkg::*;
(
    input  logic [2:0] op,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_LOAD;
        case (op) inside
            OP_LOAD:                  op_class = CLS_LOAD;
            OP_ADD:                   op_class = CLS_ADD;
            OP_BURST:                 op_class = CLS_BURST;
            OP_CLR_LO, OP_CLR_HI:     op_class = CLS_CLEAR;
            [OP_XOR_LO:OP_XOR_HI]:    op_class = CLS_XOR;
            default:                  op_class = CLS_LOAD;
        endcase
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: accepts opcode/operand commands, updates an accumulator and
// returns one result (or BURST_LEN results for BURST) over a valid/ready channel.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_reg, state_next;
    op_class_t        cls_reg, cls_next, cls_dec;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    cmd_decoder u_decoder (
        .op       (i_cmd_op),
        .op_class (cls_dec)
    );

    always_comb begin
        state_next = state_reg;
        cls_next   = cls_reg;
        data_next  = data_reg;
        acc_next   = acc_reg;
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                // Ready is simply "in IDLE", so valid alone completes the handshake here.
                if (i_cmd_valid) begin
                    cls_next   = cls_dec;
                    data_next  = i_cmd_data;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                cnt_next   = '0;
                state_next = RESP;
                case (cls_reg)
                    CLS_LOAD: begin
                        acc_next = data_reg;
                        res_next = data_reg;
                    end
                    CLS_ADD: begin
                        acc_next = acc_reg + data_reg;
                        res_next = acc_reg + data_reg;
                    end
                    CLS_BURST: res_next = data_reg;
                    CLS_CLEAR: begin
                        acc_next = '0;
                        res_next = '0;
                    end
                    CLS_XOR: begin
                        acc_next = acc_reg ^ data_reg;
                        res_next = acc_reg ^ data_reg;
                    end
                    default: res_next = res_reg;
                endcase
            end
            RESP: begin
                if (i_res_ready) begin
                    if (cls_reg == CLS_BURST && cnt_reg < CNT_LAST) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        res_next = res_reg + WIDTH'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cls_reg   <= CLS_LOAD;
            data_reg  <= '0;
            acc_reg   <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cls_reg   <= cls_next;
            data_reg  <= data_next;
            acc_reg   <= acc_next;
            res_reg   <= res_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign o_cmd_ready = (state_reg == IDLE);
    assign o_busy      = (state_reg != IDLE);
    assign o_res_valid = (state_reg == RESP);
    assign o_res_data  = res_reg;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: directed scenarios followed by random
// commands, checked cycle-by-cycle against an arithmetic reference model.
module tb_cmd_sequencer;

    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 3;
    localparam int MOD       = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int model_acc = 0;
    int exp_q[$];

    cmd_sequencer #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: results each command should produce, and the accumulator after it.
    function automatic void model_cmd(input int op, input int data);
        exp_q.delete();
        if (op == 0) begin
            model_acc = data;
            exp_q.push_back(model_acc);
        end else if (op == 1) begin
            model_acc = (model_acc + data) % MOD;
            exp_q.push_back(model_acc);
        end else if (op == 2) begin
            for (int i = 0; i < BURST_LEN; i++) exp_q.push_back((data + i) % MOD);
        end else if (op == 3 || op == 4) begin
            model_acc = 0;
            exp_q.push_back(0);
        end else begin
            model_acc = model_acc ^ data;
            exp_q.push_back(model_acc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and consume all of its results, stalling each
    // result for a number of cycles chosen in [stall_lo, stall_hi].
    task automatic do_cmd(input int op, input int data, input int stall_lo, input int stall_hi);
        int stall;
        int exp;
        model_cmd(op, data);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = WIDTH'(data);
        res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("exec_busy", busy, 1);
        chk("exec_res_valid", res_valid, 0);
        chk("exec_cmd_ready", cmd_ready, 0);
        step();
        for (int k = 0; k < exp_q.size(); k++) begin
            exp   = exp_q[k];
            stall = int'($urandom_range(stall_hi, stall_lo));
            for (int s = 0; s < stall; s++) begin
                res_ready = 1'b0;
                cmd_valid = 1'b1;
                cmd_op    = 3'($urandom_range(7, 0));
                cmd_data  = WIDTH'($urandom_range(MOD - 1, 0));
                chk("stall_res_valid", res_valid, 1);
                chk("stall_res_data", res_data, exp);
                chk("stall_cmd_ready", cmd_ready, 0);
                step();
            end
            cmd_valid = 1'b0;
            chk("res_valid", res_valid, 1);
            chk("res_data", res_data, exp);
            res_ready = 1'b1;
            step();
        end
        res_ready = 1'b0;
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
        $display("op=%0d data=0x%02h results=%0d acc=0x%02h", op, data, exp_q.size(), model_acc);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);

        do_cmd(0, 'h10, 0, 0);
        do_cmd(1, 'hF5, 0, 0);
        do_cmd(2, 'hFE, 0, 0);
        do_cmd(1, 'h00, 0, 0);
        do_cmd(0, 'h0F, 0, 0);
        for (int op = 3; op <= 7; op++) do_cmd(op, 'hFF, 0, 0);
        do_cmd(0, 'h5A, 5, 5);

        // Reset in the middle of a burst, with a command presented during reset.
        model_cmd(2, 'h20);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_data  = 8'h20;
        res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("mid_burst_first", res_data, exp_q[0]);
        step();
        chk("mid_burst_second", res_data, exp_q[1]);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_data  = 8'hAA;
        step();
        model_acc = 0;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_busy", busy, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        step();
        chk("post_rst_not_accepted", busy, 0);
        do_cmd(1, 'h01, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_cmd(int'($urandom_range(7, 0)), int'($urandom_range(MOD - 1, 0)), 0, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
